// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - two-field BCD converter and 4-digit multiplexed seven-segment driver
module seg7_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cnt_lo,
    input  logic [7:0] cnt_hi,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic       ovf
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [7:0] MAXV = 8'd99;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    logic [PW-1:0]   pcnt;
    logic [1:0]      idx;
    logic            tick;
    logic            frame;
    state_t          state;
    logic [15:0]     sr;
    logic [1:0]      sh_ovf;
    logic [3:0]      scnt;
    logic [7:0]      bcd_lo;
    logic [7:0]      bcd_hi;
    logic [3:0][3:0] dig;
    logic [7:0]      adj_val;
    logic [7:0]      shifted;

    function automatic logic [7:0] adj3(input logic [7:0] b);
        logic [3:0] o;
        logic [3:0] t;
        o = b[3:0];
        t = b[7:4];
        if (o >= 4'd5) o = o + 4'd3;
        if (t >= 4'd5) t = t + 4'd3;
        return {t, o};
    endfunction

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign tick    = (pcnt == PMAX);
    assign frame   = tick && (idx == 2'd3);
    assign adj_val = adj3(scnt[3] ? bcd_hi : bcd_lo);
    assign shifted = {adj_val[6:0], sr[15]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // sr holds the saturated {lo, hi} shadow; it is consumed MSB-first by the converter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            sh_ovf <= 2'b00;
            scnt   <= '0;
            bcd_lo <= '0;
            bcd_hi <= '0;
            dig    <= '0;
            busy   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame) begin
                        sr     <= {(cnt_lo > MAXV) ? MAXV : cnt_lo,
                                   (cnt_hi > MAXV) ? MAXV : cnt_hi};
                        sh_ovf <= {cnt_hi > MAXV, cnt_lo > MAXV};
                        scnt   <= '0;
                        bcd_lo <= '0;
                        bcd_hi <= '0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    if (scnt[3]) bcd_hi <= shifted;
                    else         bcd_lo <= shifted;
                    sr   <= {sr[14:0], 1'b0};
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'd15) state <= COMMIT;
                end
                COMMIT: begin
                    dig   <= {bcd_hi[7:4], bcd_hi[3:0], bcd_lo[7:4], bcd_lo[3:0]};
                    ovf   <= |sh_ovf;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_lut(dig[idx]);
            dp  <= (idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display
module tb_seg7_scan_display;

    localparam int SD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cnt_lo = 8'd0;
    logic [7:0] cnt_hi = 8'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       ovf;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(SD)) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt_lo (cnt_lo),
        .cnt_hi (cnt_hi),
        .an     (an),
        .seg    (seg),
        .dp     (dp),
        .busy   (busy),
        .ovf    (ovf)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ovf;
    } item_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
        logic       o;
    } vec_t;

    item_t exp_q[$];
    vec_t  vt[6];
    int    checks = 0;
    int    errors = 0;
    logic  prev_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic o);
        exp_q.push_back('{an: 4'b1110, seg: s0, dp: 1'b1, ovf: o});
        exp_q.push_back('{an: 4'b1101, seg: s1, dp: 1'b1, ovf: o});
        exp_q.push_back('{an: 4'b1011, seg: s2, dp: 1'b0, ovf: o});
        exp_q.push_back('{an: 4'b0111, seg: s3, dp: 1'b1, ovf: o});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic run_vec(input int v);
        int  n;
        int  len;
        logic bad_ovf;
        cnt_lo = vt[v].lo;
        cnt_hi = vt[v].hi;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d busy rise seen", v), (n < 200), 1);
        len = 0;
        bad_ovf = 1'b0;
        while (busy === 1'b1 && len < 40) begin
            len++;
            if (ovf !== prev_ovf) bad_ovf = 1'b1;
            if (v == 1 && len == 4) cnt_lo = 8'd59;
            @(negedge clk);
        end
        check($sformatf("v%0d busy length", v), len, 17);
        check($sformatf("v%0d ovf held during busy", v), bad_ovf, 0);
        check($sformatf("v%0d ovf after commit", v), ovf, vt[v].o);
        push_frame(vt[v].s0, vt[v].s1, vt[v].s2, vt[v].s3, vt[v].o);
        prev_ovf = vt[v].o;
    endtask

    // monitor: a newly presented digit is compared against the scoreboard head
    initial begin
        logic [3:0] prev;
        prev = 4'hF;
        forever begin
            @(negedge clk);
            if (an !== prev && exp_q.size() > 0 && exp_q[0].an == an) begin
                item_t e;
                e = exp_q.pop_front();
                check($sformatf("digit an=%b {an,seg,dp,ovf}", an), {an, seg, dp, ovf}, e);
            end
            prev = an;
        end
    end

    initial begin
        @(negedge rst);
        for (int i = 0; i < 25; i++) begin
            int k;
            logic [3:0] ea;
            @(negedge clk);
            k  = (i / SD) % 4;
            ea = ~(4'(1) << k);
            check($sformatf("scan an cycle %0d", i), an, ea);
            check($sformatf("scan dp cycle %0d", i), dp, (k != 2));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'd37,  8'd12,  7'h78, 7'h30, 7'h24, 7'h79, 1'b0};
        vt[1] = '{8'd60,  8'd0,   7'h40, 7'h02, 7'h40, 7'h40, 1'b0};
        vt[2] = '{8'd59,  8'd150, 7'h10, 7'h12, 7'h10, 7'h10, 1'b1};
        vt[3] = '{8'd0,   8'd5,   7'h40, 7'h40, 7'h12, 7'h40, 1'b0};
        vt[4] = '{8'd99,  8'd100, 7'h10, 7'h10, 7'h10, 7'h10, 1'b1};
        vt[5] = '{8'd255, 8'd8,   7'h10, 7'h10, 7'h00, 7'h40, 1'b1};

        rst = 1'b1;
        repeat (3) begin
            cnt_lo = 8'($urandom);
            cnt_hi = 8'($urandom);
            @(negedge clk);
        end
        check("reset an", an, 4'hF);
        check("reset seg", seg, 7'h7F);
        check("reset dp", dp, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset ovf", ovf, 1'b0);

        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        cnt_lo = vt[0].lo;
        cnt_hi = vt[0].hi;
        rst = 1'b0;
        @(negedge clk);
        check("first an", an, 4'b1110);
        check("first seg", seg, 7'h40);

        for (int v = 0; v < 6; v++) run_vec(v);
        drain("scoreboard drained after vectors");

        cnt_lo = 8'd37;
        cnt_hi = 8'd12;
        begin
            int n;
            n = 0;
            while (busy !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("abort busy rise seen", (n < 200), 1);
        end
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort busy before reset", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 1'b0);
        check("abort an", an, 4'hF);
        check("abort seg", seg, 7'h7F);
        check("abort ovf", ovf, 1'b0);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        rst = 1'b0;
        drain("scoreboard drained after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
